mem_access_stage: RTL and testbench

Memory-access stage of the 8-bit pipeline, between the EX/MEM register and the MEM/WB register. Holds the 256×8 data memory and the 8-bit stack pointer, and executes load, store, push and pop for the instruction in MEM. Also runs a two-cycle interrupt-entry sequence that pushes the return PC and the flags while stalling the pipeline. Its `read_data_M` output feeds the MEM/WB register.

---
 rtl/mem_access_stage.sv | 168 ++++++++++++++++
 tb/tb_mem_access_stage.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// Memory-access stage: 256x8 data memory, stack pointer, load/store/push/pop and
// a two-cycle interrupt-entry save sequence. Optional macro STACK_GUARD_EN adds stack bounds guarding.
module mem_access_stage #(
  parameter logic [7:0] SP_INIT = 8'hFF,
  parameter int         FLAG_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_wr_M,
  input  logic              mem_rd_M,
  input  logic              push_M,
  input  logic              pop_M,
  input  logic [7:0]        addr_M,
  input  logic [7:0]        wdata_M,
  input  logic              intr,
  input  logic [7:0]        pc_ret,
  input  logic [FLAG_W-1:0] flags_in,
  output logic [7:0]        read_data_M,
  output logic [7:0]        sp,
  output logic              stall,
  output logic              intr_ack,
  output logic              stack_err
);

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    SAVE_PC  = 2'b01,
    SAVE_FLG = 2'b10
  } state_t;

  state_t      state_r;
  state_t      state_next_s;
  logic [7:0]  mem_r [0:255];
  logic [7:0]  sp_r;
  logic [7:0]  sp_next_s;
  logic [7:0]  sp_inc_s;
  logic [7:0]  sp_dec_s;
  logic        we_s;
  logic [7:0]  waddr_s;
  logic [7:0]  wdata_s;
  logic        push_ok_s;
  logic        pop_ok_s;
  logic        intr_ack_r;

  assign sp_inc_s = sp_r + 8'd1;
  assign sp_dec_s = sp_r - 8'd1;
  assign sp       = sp_r;
  assign stall    = (state_r != IDLE);
  assign intr_ack = intr_ack_r;

`ifdef STACK_GUARD_EN
  logic err_set_s;
  logic stack_err_r;

  assign push_ok_s = (sp_r != 8'h00);
  assign pop_ok_s  = (sp_r != SP_INIT);
  // Only an op that actually wins priority can trip the guard.
  assign err_set_s = (state_r == IDLE) ? (push_M ? ~push_ok_s : (pop_M & ~pop_ok_s))
                                       : ~push_ok_s;
  assign stack_err = stack_err_r;

  // Sticky stack error flag, cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stack_err_r <= 1'b0;
    end else if (err_set_s) begin
      stack_err_r <= 1'b1;
    end else begin
      stack_err_r <= stack_err_r;
    end
  end
`else
  assign push_ok_s = 1'b1;
  assign pop_ok_s  = 1'b1;
  assign stack_err = 1'b0;
`endif

  // Next state, stack pointer, memory write port and read mux.
  always_comb begin
    state_next_s = state_r;
    sp_next_s    = sp_r;
    we_s         = 1'b0;
    waddr_s      = sp_r;
    wdata_s      = wdata_M;
    read_data_M  = 8'h00;
    case (state_r)
      IDLE: begin
        if (mem_rd_M) begin
          read_data_M = mem_r[addr_M];
        end else begin
          read_data_M = 8'h00;
        end
        if (push_M) begin
          if (push_ok_s) begin
            we_s      = 1'b1;
            sp_next_s = sp_dec_s;
          end else begin
            we_s = 1'b0;
          end
        end else if (pop_M) begin
          // Pop owns the read port, even when a load is also asserted.
          if (pop_ok_s) begin
            read_data_M = mem_r[sp_inc_s];
            sp_next_s   = sp_inc_s;
          end else begin
            read_data_M = 8'h00;
          end
        end else if (mem_wr_M) begin
          we_s    = 1'b1;
          waddr_s = addr_M;
        end else begin
          we_s = 1'b0;
        end
        if (intr) begin
          state_next_s = SAVE_PC;
        end else begin
          state_next_s = IDLE;
        end
      end
      SAVE_PC: begin
        wdata_s = pc_ret;
        if (push_ok_s) begin
          we_s      = 1'b1;
          sp_next_s = sp_dec_s;
        end else begin
          we_s = 1'b0;
        end
        state_next_s = SAVE_FLG;
      end
      SAVE_FLG: begin
        wdata_s = 8'(flags_in);
        if (push_ok_s) begin
          we_s      = 1'b1;
          sp_next_s = sp_dec_s;
        end else begin
          we_s = 1'b0;
        end
        state_next_s = IDLE;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State, stack pointer and acknowledge registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= IDLE;
      sp_r       <= SP_INIT;
      intr_ack_r <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      sp_r       <= sp_next_s;
      intr_ack_r <= (state_next_s == SAVE_FLG);
    end
  end

  // Data memory write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (we_s) begin
      mem_r[waddr_s] <= wdata_s;
    end else begin
      mem_r[waddr_s] <= mem_r[waddr_s];
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: a stack/memory reference model predicts each
// cycle's outputs into a queue that an independent monitor checks on the falling edge.
module tb_mem_access_stage;

  localparam logic [7:0] SP_INIT = 8'hFF;
  localparam int         FLAG_W  = 4;
`ifdef STACK_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic              clk;
  logic              reset;
  logic              mem_wr_M;
  logic              mem_rd_M;
  logic              push_M;
  logic              pop_M;
  logic [7:0]        addr_M;
  logic [7:0]        wdata_M;
  logic              intr;
  logic [7:0]        pc_ret;
  logic [FLAG_W-1:0] flags_in;
  logic [7:0]        read_data_M;
  logic [7:0]        sp;
  logic              stall;
  logic              intr_ack;
  logic              stack_err;

  mem_access_stage #(.SP_INIT(SP_INIT), .FLAG_W(FLAG_W)) dut (
    .clk(clk), .reset(reset), .mem_wr_M(mem_wr_M), .mem_rd_M(mem_rd_M),
    .push_M(push_M), .pop_M(pop_M), .addr_M(addr_M), .wdata_M(wdata_M),
    .intr(intr), .pc_ret(pc_ret), .flags_in(flags_in),
    .read_data_M(read_data_M), .sp(sp), .stall(stall),
    .intr_ack(intr_ack), .stack_err(stack_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] rd;
    logic [7:0] sp;
    logic       stall;
    logic       ack;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: memory array, stack pointer, remaining save cycles position.
  logic [7:0] m_mem [256];
  int         m_sp    = 255;
  int         m_phase = 0;
  bit         m_err   = 1'b0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %02h, expected %02h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic step(input bit push, input bit pop, input bit wr, input bit rd,
                      input logic [7:0] addr, input logic [7:0] wdata,
                      input bit irq, input logic [7:0] pc, input logic [3:0] flg,
                      input bit rst);
    exp_t       e;
    logic [7:0] val;
    @(posedge clk);
    #1;
    push_M = push; pop_M = pop; mem_wr_M = wr; mem_rd_M = rd;
    addr_M = addr; wdata_M = wdata; intr = irq; pc_ret = pc; flags_in = flg;
    reset = rst ? 1'b0 : 1'b1;
    if (rst) begin
      m_sp = 255; m_phase = 0; m_err = 1'b0;
    end
    e.stall = (m_phase != 0);
    e.ack   = (m_phase == 2);
    e.sp    = m_sp[7:0];
    e.err   = m_err;
    if (m_phase != 0) e.rd = 8'h00;
    else if (pop && !push) e.rd = (GUARD && m_sp == 255) ? 8'h00 : m_mem[(m_sp + 1) % 256];
    else if (rd) e.rd = m_mem[addr];
    else e.rd = 8'h00;
    exp_q.push_back(e);
    // Effect of the coming clock edge.
    if (m_phase == 0) begin
      if (push) begin
        if (GUARD && m_sp == 0) m_err = 1'b1;
        else begin m_mem[m_sp] = wdata; m_sp = (m_sp + 255) % 256; end
      end else if (pop) begin
        if (GUARD && m_sp == 255) m_err = 1'b1;
        else m_sp = (m_sp + 1) % 256;
      end else if (wr) begin
        m_mem[addr] = wdata;
      end
      m_phase = irq ? 1 : 0;
    end else begin
      val = (m_phase == 1) ? pc : {4'b0000, flg};
      if (GUARD && m_sp == 0) m_err = 1'b1;
      else begin m_mem[m_sp] = val; m_sp = (m_sp + 255) % 256; end
      m_phase = (m_phase == 1) ? 2 : 0;
    end
    if (rst) begin
      @(negedge clk);
      #1;
      reset = 1'b1;
    end
  endtask

  task automatic idle(input bit rst);
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 4'h0, rst);
  endtask

  task automatic load(input logic [7:0] a);
    step(1'b0, 1'b0, 1'b0, 1'b1, a, 8'h00, 1'b0, 8'h00, 4'h0, 1'b0);
  endtask

  // Monitor: compares every presented cycle against the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("read_data_M", read_data_M, e.rd);
        check("sp", sp, e.sp);
        check("stall", {7'd0, stall}, {7'd0, e.stall});
        check("intr_ack", {7'd0, intr_ack}, {7'd0, e.ack});
        check("stack_err", {7'd0, stack_err}, {7'd0, e.err});
      end
    end
  end

  initial begin
    reset = 1'b0; push_M = 1'b0; pop_M = 1'b0; mem_wr_M = 1'b0; mem_rd_M = 1'b0;
    addr_M = 8'h00; wdata_M = 8'h00; intr = 1'b0; pc_ret = 8'h00; flags_in = 4'h0;
    idle(1'b1);
    for (int i = 0; i < 256; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0, 8'(i), 8'($urandom), 1'b0, 8'h00, 4'h0, 1'b0);
    end
    // Push then pop, then read back the stack slot.
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'hA5, 1'b0, 8'h00, 4'h0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 4'h0, 1'b0);
    load(8'hFF);
    // Store/load visibility and same-cycle old data.
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h10, 8'h3C, 1'b0, 8'h00, 4'h0, 1'b0);
    load(8'h10);
    step(1'b0, 1'b0, 1'b1, 1'b1, 8'h10, 8'h77, 1'b0, 8'h00, 4'h0, 1'b0);
    load(8'h10);
    // Push wins over pop at sp=FE.
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h11, 1'b0, 8'h00, 4'h0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h22, 1'b0, 8'h00, 4'h0, 1'b0);
    load(8'hFE);
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 4'h0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 4'h0, 1'b0);
    // Interrupt entry with a push held across the stall.
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h42, 4'b1010, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h99, 1'b0, 8'h42, 4'b1010, 1'b0);
    end
    load(8'hFF);
    load(8'hFE);
    load(8'hFD);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 4'h0, 1'b0);
    end
    // Reset in SAVE_FLG.
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h55, 4'h3, 1'b0);
    idle(1'b0);
    idle(1'b1);
    idle(1'b0);
    load(8'hFF);
    // Pop on an empty stack.
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 4'h0, 1'b0);
    idle(1'b0);
    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      step(($urandom % 4) == 0, ($urandom % 4) == 0, ($urandom % 3) == 0,
           ($urandom % 2) == 0, 8'($urandom), 8'($urandom), ($urandom % 16) == 0,
           8'($urandom), 4'($urandom), ($urandom % 400) == 0);
    end
    @(negedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d predictions left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
